// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response pair, with a
// programmable number of wait states between request acceptance and the access.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  enter_resp;

  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  mem_we;

  logic [31:0] mem_q [2**DEPTH_LOG2];

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request instead of the (not yet loaded) latched copy.
  always_comb begin
    acc_write = (state_q == IDLE) ? req_write : write_q;
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_be    = (state_q == IDLE) ? req_be    : be_q;
    acc_idx   = acc_addr[DEPTH_LOG2+1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      error_d = acc_err;
      rdata_d = (!acc_write && !acc_err) ? mem_q[acc_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Writes are gated by reset so a store caught by reset never lands.
  assign mem_we = rst_n && enter_resp && acc_write && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 1, 3 and 0 wait states.
module tb_data_mem_responder;

  typedef struct {
    string       nm;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_error [3];

  int n_cmp = 0;
  int n_err = 0;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_be(req_be[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $fatal(1, "timeout");
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response with rsp_ready held high; checks latency too.
  task automatic txn(input int d, input vec_t v);
    int lat;
    chk($sformatf("%s_ready_d%0d", v.nm, d), {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = v.write;
    req_addr[d]  = v.addr;
    req_wdata[d] = v.wdata;
    req_be[d]    = v.be;
    tick();
    req_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 20) begin
      tick();
      lat++;
    end
    chk($sformatf("%s_latency_d%0d", v.nm, d), lat, ws_of(d));
    chk($sformatf("%s_rdata_d%0d", v.nm, d), rsp_rdata[d], v.exp_rdata);
    chk($sformatf("%s_error_d%0d", v.nm, d), {31'd0, rsp_error[d]}, {31'd0, v.exp_err});
    tick();
    chk($sformatf("%s_idle_d%0d", v.nm, d), {31'd0, req_ready[d]}, 32'd1);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    tbl.push_back('{"st10",    1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        0});
    tbl.push_back('{"ld10",    0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 0});
    tbl.push_back('{"st20",    1, 32'h20,       32'h11223344, 4'hF, 32'h0,        0});
    tbl.push_back('{"st20be5", 1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        0});
    tbl.push_back('{"ld20a",   0, 32'h20,       32'h0,        4'hF, 32'h11BB33DD, 0});
    tbl.push_back('{"st20be0", 1, 32'h20,       32'hFFFFFFFF, 4'h0, 32'h0,        0});
    tbl.push_back('{"ld20b",   0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 0});
    tbl.push_back('{"ld13",    0, 32'h13,       32'h0,        4'h0, 32'h0,        1});
    tbl.push_back('{"st0",     1, 32'h0,        32'h01020304, 4'hF, 32'h0,        0});
    tbl.push_back('{"st1000",  1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1});
    tbl.push_back('{"ld0",     0, 32'h0,        32'h0,        4'h0, 32'h01020304, 0});
    tbl.push_back('{"stFFC",   1, 32'hFFC,      32'hCAFEF00D, 4'hF, 32'h0,        0});
    tbl.push_back('{"ldFFC",   0, 32'hFFC,      32'h0,        4'h0, 32'hCAFEF00D, 0});
    tbl.push_back('{"st12",    1, 32'h12,       32'h55555555, 4'hF, 32'h0,        1});
    tbl.push_back('{"ld10b",   0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 0});
    tbl.push_back('{"ldhi",    0, 32'h80000010, 32'h0,        4'h0, 32'h0,        1});
    tbl.push_back('{"st10be8", 1, 32'h10,       32'h77000000, 4'h8, 32'h0,        0});
    tbl.push_back('{"ld10c",   0, 32'h10,       32'h0,        4'h0, 32'h77ADBEEF, 0});

    // Reset held for two edges with a store request pending on every instance.
    for (int d = 0; d < 3; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'h5A5A5A5A;
      req_be[d]    = 4'hF;
      rsp_ready[d] = 1'b1;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready_d%0d", d), {31'd0, req_ready[d]}, 32'd1);
      chk($sformatf("rst_valid_d%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("rst_rdata_d%0d", d), rsp_rdata[d], 32'd0);
      chk($sformatf("rst_error_d%0d", d), {31'd0, rsp_error[d]}, 32'd0);
      req_valid[d] = 1'b0;
      rst_n[d]     = 1'b1;
    end
    tick();

    for (int i = 0; i < tbl.size(); i++) txn(0, tbl[i]);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_valid_%0d", i), {31'd0, rsp_valid[0]}, 32'd1);
      chk($sformatf("bp_rdata_%0d", i), rsp_rdata[0], 32'h77ADBEEF);
      chk($sformatf("bp_ready_%0d", i), {31'd0, req_ready[0]}, 32'd0);
      if (i < 5) tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    chk("bp_release_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("bp_release_valid", {31'd0, rsp_valid[0]}, 32'd0);

    // Three wait states: reset one cycle after a store is accepted discards it.
    v = '{"st40", 1, 32'h40, 32'h12345678, 4'hF, 32'h0, 0};
    txn(1, v);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'h9999AAAA;
    req_be[1]    = 4'hF;
    tick();
    req_valid[1] = 1'b0;
    chk("midwait_in_wait", {31'd0, req_ready[1]}, 32'd0);
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    chk("midwait_rst_ready", {31'd0, req_ready[1]}, 32'd1);
    chk("midwait_rst_valid", {31'd0, rsp_valid[1]}, 32'd0);
    tick();
    tick();
    tick();
    chk("midwait_stays_idle", {31'd0, rsp_valid[1]}, 32'd0);
    v = '{"ld40", 0, 32'h40, 32'h0, 4'h0, 32'h12345678, 0};
    txn(1, v);

    // Zero wait states: single-cycle path, and reset blocks a pending store.
    v = '{"z_st10", 1, 32'h10, 32'h0BADF00D, 4'hF, 32'h0, 0};
    txn(2, v);
    v = '{"z_ld10", 0, 32'h10, 32'h0, 4'h0, 32'h0BADF00D, 0};
    txn(2, v);
    rst_n[2]     = 1'b0;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h10;
    req_wdata[2] = 32'h5A5A5A5A;
    req_be[2]    = 4'hF;
    tick();
    tick();
    chk("z_rst_valid", {31'd0, rsp_valid[2]}, 32'd0);
    req_valid[2] = 1'b0;
    rst_n[2]     = 1'b1;
    tick();
    v = '{"z_ld10b", 0, 32'h10, 32'h0, 4'h0, 32'h0BADF00D, 0};
    txn(2, v);
    v = '{"z_ld13", 0, 32'h13, 32'h0, 4'h0, 32'h0, 1};
    txn(2, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
